keypad_entry: RTL and testbench

Debounced key-event generator and digit-entry buffer that sits directly downstream of the keypad column scanner. It watches the raw keypad row pins to decide when a key is physically down or up. It samples the scanner's 4-bit decoded key code to produce exactly one event per press. Events are folded into a BCD entry buffer with backspace, clear and enter editing, and the committed value is presented to the lab's application logic with a one-cycle valid strobe.

---
 rtl/keypad_entry.sv | 173 +++++++++++++++++
 tb/tb_keypad_entry.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry.sv
// Debounced keypad event generator feeding a BCD digit-entry buffer.
// Row activity is judged once per scan window; one key_event per qualified press.
module keypad_entry #(
    parameter int SCAN_CYCLES      = 400000,
    parameter int DEBOUNCE_WINDOWS = 3,
    parameter int DIGITS           = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [3:0]                     row,
    input  logic [3:0]                     key_code,
    output logic                           key_event,
    output logic [3:0]                     key_value,
    output logic [4*DIGITS-1:0]            entry_value,
    output logic [$clog2(DIGITS+1)-1:0]    digit_count,
    output logic                           overflow,
    output logic [4*DIGITS-1:0]            commit_value,
    output logic                           commit_valid
);
    localparam int CNT_W = $clog2(SCAN_CYCLES);
    localparam int ENT_W = 4 * DIGITS;
    localparam int DC_W  = $clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0] WRAP_AT  = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [3:0]       DEB_WIN  = 4'(DEBOUNCE_WINDOWS);
    localparam logic [DC_W-1:0]  DIG_MAX  = DC_W'(DIGITS);

    typedef enum logic [1:0] {IDLE, PRESS_PEND, HELD, REL_PEND} state_t;

    logic [3:0]       row_p0, row_p1;
    logic [CNT_W-1:0] win_cnt;
    logic             wrap, row_low, row_seen, active;
    state_t           state, state_nx;
    logic [3:0]       cnt, cnt_nx;
    logic             ev_fire;

    // Stage p0/p1: two-flop synchronizer on the asynchronous row pins
    always_ff @(posedge clk) begin
        if (rst) begin
            row_p0 <= 4'b1111;
            row_p1 <= 4'b1111;
        end else begin
            row_p0 <= row;
            row_p1 <= row_p0;
        end
    end

    assign row_low = ~&row_p1;
    assign wrap    = (win_cnt == WRAP_AT);
    assign active  = row_seen | row_low;

    // Window timing and per-window activity capture
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt  <= '0;
            row_seen <= 1'b0;
        end else begin
            win_cnt  <= wrap ? '0 : win_cnt + 1'b1;
            row_seen <= wrap ? 1'b0 : (row_seen | row_low);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else if (wrap) begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (active) begin
                    state_nx = PRESS_PEND;
                    cnt_nx   = 4'd1;
                end
            end
            PRESS_PEND: begin
                if (!active)
                    state_nx = IDLE;
                else if ((cnt + 4'd1) == DEB_WIN)
                    state_nx = HELD;
                else
                    cnt_nx = cnt + 4'd1;
            end
            HELD: begin
                if (!active) begin
                    state_nx = REL_PEND;
                    cnt_nx   = 4'd1;
                end
            end
            REL_PEND: begin
                if (active)
                    state_nx = HELD;
                else if ((cnt + 4'd1) == DEB_WIN)
                    state_nx = IDLE;
                else
                    cnt_nx = cnt + 4'd1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ev_fire = 1'b0;
        if (wrap && state == PRESS_PEND && active && (cnt + 4'd1) == DEB_WIN)
            ev_fire = 1'b1;
    end

    // Stage p2: registered event and latched key code
    always_ff @(posedge clk) begin
        if (rst) begin
            key_event <= 1'b0;
            key_value <= 4'd0;
        end else begin
            key_event <= ev_fire;
            if (ev_fire)
                key_value <= key_code;
        end
    end

    // Buffer edits take effect on the edge that ends the key_event cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_value  <= '0;
            digit_count  <= '0;
            overflow     <= 1'b0;
            commit_value <= '0;
            commit_valid <= 1'b0;
        end else begin
            commit_valid <= 1'b0;
            if (key_event) begin
                if (key_value <= 4'd9) begin
                    if (digit_count < DIG_MAX) begin
                        entry_value <= (entry_value << 4) | ENT_W'(key_value);
                        digit_count <= digit_count + 1'b1;
                    end else begin
                        overflow <= 1'b1;
                    end
                end else begin
                    case (key_value)
                        4'hB: begin
                            if (digit_count != '0) begin
                                entry_value <= entry_value >> 4;
                                digit_count <= digit_count - 1'b1;
                            end
                            overflow <= 1'b0;
                        end
                        4'hC: begin
                            entry_value <= '0;
                            digit_count <= '0;
                            overflow    <= 1'b0;
                        end
                        4'hE: begin
                            if (digit_count != '0) begin
                                commit_value <= entry_value;
                                commit_valid <= 1'b1;
                                entry_value  <= '0;
                                digit_count  <= '0;
                                overflow     <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry: models the scanner by driving row/key_code
// and scoreboards key events and commits against expected queues.
module tb_keypad_entry;
    localparam int SC = 16;
    localparam int DW = 3;
    localparam int DG = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row;
    logic [3:0]  key_code;
    logic        key_event;
    logic [3:0]  key_value;
    logic [15:0] entry_value;
    logic [2:0]  digit_count;
    logic        overflow;
    logic [15:0] commit_value;
    logic        commit_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0]  exp_q[$];
    logic [3:0]  got_q[$];
    logic [15:0] cv_q[$];

    keypad_entry #(.SCAN_CYCLES(SC), .DEBOUNCE_WINDOWS(DW), .DIGITS(DG)) dut (
        .clk(clk), .rst(rst), .row(row), .key_code(key_code),
        .key_event(key_event), .key_value(key_value),
        .entry_value(entry_value), .digit_count(digit_count), .overflow(overflow),
        .commit_value(commit_value), .commit_valid(commit_valid)
    );

    always #5 clk = ~clk;

    // One clock; outputs sampled 1 time unit after the active edge
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (key_event) got_q.push_back(key_value);
            if (commit_valid) cv_q.push_back(commit_value);
        end
    endtask

    task automatic press(input logic [3:0] k, input int hold_w, input int rel_w, input bit expect_ev);
        if (expect_ev) exp_q.push_back(k);
        row = 4'b1110;
        key_code = k;
        tick(hold_w * SC);
        row = 4'b1111;
        tick(rel_w * SC);
    endtask

    task automatic clear_sb();
        exp_q.delete();
        got_q.delete();
        cv_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; row = 4'b1111; key_code = 4'd0;
        tick(2);
        n_checks++;
        if ({key_event, commit_valid, overflow} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000", {key_event, commit_valid, overflow});
        end
        n_checks++;
        if ({key_value, entry_value, digit_count, commit_value} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got kv=%h ev=%h dc=%0d cv=%h expected all 0",
                     key_value, entry_value, digit_count, commit_value);
        end
        rst = 1'b0;
        clear_sb();
        tick(20 * SC);
        n_checks++;
        if (got_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_quiet: got %0d events expected 0", got_q.size());
        end
    endtask

    task automatic test_basic_entry();
        clear_sb();
        press(4'd1, 5, 5, 1'b1);
        press(4'd2, 5, 5, 1'b1);
        press(4'd3, 5, 5, 1'b1);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL basic_count: got %0d events expected %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            logic [3:0] e, g;
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL basic_key_value: got %h expected %h", g, e);
            end
        end
        n_checks++;
        if (entry_value !== 16'h0123 || digit_count !== 3'd3) begin
            n_fail++;
            $display("FAIL basic_buffer: got %h/%0d expected 0123/3", entry_value, digit_count);
        end
    endtask

    task automatic test_glitch_bounce();
        clear_sb();
        press(4'hA, 1, 5, 1'b0);
        n_checks++;
        if (got_q.size() != 0) begin
            n_fail++;
            $display("FAIL glitch_1win: got %0d events expected 0", got_q.size());
        end
        clear_sb();
        press(4'hA, 1, 2, 1'b0);
        press(4'hA, 4, 5, 1'b1);
        n_checks++;
        if (got_q.size() != 1 || (got_q.size() == 1 && got_q[0] !== exp_q[0])) begin
            n_fail++;
            $display("FAIL bounce_one_event: got %0d events expected 1 of %h", got_q.size(), exp_q[0]);
        end
        clear_sb();
        press(4'hA, 50, 5, 1'b1);
        n_checks++;
        if (got_q.size() != 1 || (got_q.size() == 1 && got_q[0] !== exp_q[0])) begin
            n_fail++;
            $display("FAIL long_hold: got %0d events expected 1", got_q.size());
        end
        n_checks++;
        if (entry_value !== 16'h0123 || digit_count !== 3'd3) begin
            n_fail++;
            $display("FAIL glitch_buffer: got %h/%0d expected 0123/3", entry_value, digit_count);
        end
    endtask

    task automatic test_overflow_backspace();
        press(4'hC, 5, 5, 1'b1);
        n_checks++;
        if (entry_value !== 16'h0 || digit_count !== 3'd0) begin
            n_fail++;
            $display("FAIL pre_clear: got %h/%0d expected 0/0", entry_value, digit_count);
        end
        for (int d = 1; d <= 5; d++) press(4'(d), 5, 5, 1'b1);
        n_checks++;
        if (entry_value !== 16'h1234 || digit_count !== 3'd4 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow: got %h/%0d/%b expected 1234/4/1", entry_value, digit_count, overflow);
        end
        press(4'hB, 5, 5, 1'b1);
        n_checks++;
        if (entry_value !== 16'h0123 || digit_count !== 3'd3 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL backspace: got %h/%0d/%b expected 0123/3/0", entry_value, digit_count, overflow);
        end
    endtask

    task automatic test_enter();
        cv_q.delete();
        press(4'hE, 5, 5, 1'b1);
        n_checks++;
        if (cv_q.size() != 1) begin
            n_fail++;
            $display("FAIL commit_pulse: got %0d valid cycles expected 1", cv_q.size());
        end else begin
            n_checks++;
            if (cv_q[0] !== 16'h0123) begin
                n_fail++;
                $display("FAIL commit_value: got %h expected 0123", cv_q[0]);
            end
        end
        n_checks++;
        if (entry_value !== 16'h0 || digit_count !== 3'd0 || commit_value !== 16'h0123) begin
            n_fail++;
            $display("FAIL enter_buffer: got %h/%0d cv=%h expected 0/0 cv=0123",
                     entry_value, digit_count, commit_value);
        end
    endtask

    task automatic test_empty_enter_clear();
        cv_q.delete();
        press(4'hE, 5, 5, 1'b1);
        n_checks++;
        if (cv_q.size() != 0) begin
            n_fail++;
            $display("FAIL empty_enter: got %0d commit pulses expected 0", cv_q.size());
        end
        press(4'd7, 5, 5, 1'b1);
        press(4'd8, 5, 5, 1'b1);
        clear_sb();
        press(4'hA, 5, 5, 1'b1);
        n_checks++;
        if (got_q.size() != 1 || (got_q.size() == 1 && got_q[0] !== 4'hA)) begin
            n_fail++;
            $display("FAIL key_a_event: got %0d events expected 1 of a", got_q.size());
        end
        n_checks++;
        if (entry_value !== 16'h0078 || digit_count !== 3'd2) begin
            n_fail++;
            $display("FAIL key_a_buffer: got %h/%0d expected 0078/2", entry_value, digit_count);
        end
        press(4'hC, 5, 5, 1'b1);
        n_checks++;
        if (entry_value !== 16'h0 || digit_count !== 3'd0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL clear: got %h/%0d/%b expected 0/0/0", entry_value, digit_count, overflow);
        end
    endtask

    task automatic test_reset_held();
        row = 4'b1110;
        key_code = 4'd9;
        tick(SC);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        clear_sb();
        exp_q.push_back(4'd9);
        tick(5 * SC);
        row = 4'b1111;
        tick(5 * SC);
        n_checks++;
        if (got_q.size() != 1 || (got_q.size() == 1 && got_q[0] !== exp_q[0])) begin
            n_fail++;
            $display("FAIL reset_held_event: got %0d events expected 1 of 9", got_q.size());
        end
        n_checks++;
        if (entry_value !== 16'h0009 || digit_count !== 3'd1) begin
            n_fail++;
            $display("FAIL reset_held_buffer: got %h/%0d expected 0009/1", entry_value, digit_count);
        end
    endtask

    initial begin
        rst = 1'b1;
        row = 4'b1111;
        key_code = 4'd0;
        test_reset();
        test_basic_entry();
        test_glitch_bounce();
        test_overflow_backspace();
        test_enter();
        test_empty_enter_clear();
        test_reset_held();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
